// File: rtl/rv32_mem_pkg.sv
// Shared RV32 memory-access definitions: load/store funct3 encodings,
// memory_controller_module instr_mode encodings, and the LSU state type.
package rv32_mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] MODE_WORD = 2'b00;
  localparam logic [1:0] MODE_BYTE = 2'b01;
  localparam logic [1:0] MODE_HALF = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } lsu_state_e;

  // Controller access size follows the low two funct3 bits.
  function automatic logic [1:0] mode_of(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return MODE_BYTE;
      2'b01:   return MODE_HALF;
      default: return MODE_WORD;
    endcase
  endfunction

  // Unsigned variants exist only for loads; anything else is undefined.
  function automatic logic funct3_bad(input logic [2:0] f3, input logic store);
    case (f3)
      F3_LB, F3_LH, F3_LW: return 1'b0;
      F3_LBU, F3_LHU:      return store;
      default:             return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// RV32 load extension: the controller zero-fills byte/half reads, so the
// signed variants are rebuilt here from the low lane.
module load_extend
  import rv32_mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] raw,
  output logic [31:0] ext
);

  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  assign byte_s = raw[7:0];
  assign half_s = raw[15:0];

  // Select sign- or zero-extension of the addressed lane.
  always_comb begin
    ext = raw;
    case (funct3)
      F3_LB:   ext = 32'(byte_s);
      F3_LBU:  ext = {24'b0, raw[7:0]};
      F3_LH:   ext = 32'(half_s);
      F3_LHU:  ext = {16'b0, raw[15:0]};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the RV32 execute stage and memory_controller_module.
// One request in flight: validate, issue a single enable pulse, wait for op_r
// (bounded by TIMEOUT), then return a one-cycle extended response.
module load_store_unit
  import rv32_mem_pkg::*;
#(
  parameter int ADDR_W  = 24,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  output logic              mem_enable,
  output logic [1:0]        mem_mode,
  input  logic              mem_op_r,
  input  logic [31:0]       mem_rdata
);

  lsu_state_e  state;
  logic [2:0]  funct3_q;
  logic [3:0]  wait_cnt;
  logic [3:0]  wait_cnt_inc;
  logic        req_fire;
  logic        req_bad;
  logic        addr_oor;
  logic        misaligned;
  logic        timed_out;
  logic [31:0] ext_data;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign mem_enable = (state == ISSUE);
  assign req_fire   = req_valid && req_ready;

  assign addr_oor   = |req_addr[31:ADDR_W];
  assign misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign req_bad    = funct3_bad(req_funct3, req_store) || addr_oor || misaligned;

  // The op_r check has priority over this, so a late op_r on the last cycle still succeeds.
  assign wait_cnt_inc = wait_cnt + 4'd1;
  assign timed_out    = (wait_cnt_inc == 4'(TIMEOUT));

  load_extend u_load_extend (
    .funct3 (funct3_q),
    .raw    (mem_rdata),
    .ext    (ext_data)
  );

  // Request sequencing and WAIT-cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_fire) state <= req_bad ? RESP : ISSUE;
        end
        ISSUE: begin
          state    <= WAIT;
          wait_cnt <= '0;
        end
        WAIT: begin
          if (mem_op_r || timed_out) state <= RESP;
          else                       wait_cnt <= wait_cnt_inc;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Latch the accepted request; these registers drive the controller and stay stable through WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      funct3_q  <= '0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      mem_mode  <= MODE_WORD;
    end else if (req_fire) begin
      funct3_q  <= req_funct3;
      mem_addr  <= req_addr[ADDR_W-1:0];
      mem_we    <= req_store;
      mem_wdata <= req_wdata;
      mem_mode  <= mode_of(req_funct3);
    end
  end

  // Response payload is loaded on entry to RESP and held until the next response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else if (req_fire && req_bad) begin
      resp_rdata <= '0;
      resp_err   <= 1'b1;
    end else if (state == WAIT) begin
      if (mem_op_r) begin
        resp_rdata <= mem_we ? 32'h0 : ext_data;
        resp_err   <= 1'b0;
      end else if (timed_out) begin
        resp_rdata <= '0;
        resp_err   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a byte-array controller stub with programmable
// op_r delay, a table of directed requests, and hand-written timeout/reset sequences.
module tb_load_store_unit;
  import rv32_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [23:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        mem_enable;
  logic [1:0]  mem_mode;
  logic        mem_op_r;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(24), .TIMEOUT(15)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_enable (mem_enable),
    .mem_mode   (mem_mode),
    .mem_op_r   (mem_op_r),
    .mem_rdata  (mem_rdata)
  );

  // Controller stub: 256-byte memory, zero-filled byte/half reads, op_r after stub_delay cycles.
  bit [7:0]    mem [256];
  int          stub_delay = 4;
  bit          stub_mute = 1'b0;
  int          stub_cnt;
  logic [31:0] stub_data;

  always @(posedge clk) begin
    logic [7:0] a;
    if (!rst_n) begin
      stub_cnt  <= 0;
      mem_op_r  <= 1'b0;
      mem_rdata <= 32'hdeadbeef;
    end else begin
      mem_op_r  <= 1'b0;
      mem_rdata <= 32'hdeadbeef;
      if (mem_enable) begin
        a = mem_addr[7:0];
        if (mem_we) begin
          case (mem_mode)
            MODE_BYTE: mem[a] <= mem_wdata[7:0];
            MODE_HALF: begin
              mem[a]        <= mem_wdata[7:0];
              mem[a + 8'd1] <= mem_wdata[15:8];
            end
            MODE_WORD: begin
              mem[a]        <= mem_wdata[7:0];
              mem[a + 8'd1] <= mem_wdata[15:8];
              mem[a + 8'd2] <= mem_wdata[23:16];
              mem[a + 8'd3] <= mem_wdata[31:24];
            end
            default: ;
          endcase
          stub_data <= 32'hfeedface;
        end else begin
          case (mem_mode)
            MODE_BYTE: stub_data <= {24'h0, mem[a]};
            MODE_HALF: stub_data <= {16'h0, mem[a + 8'd1], mem[a]};
            MODE_WORD: stub_data <= {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]};
            default:   stub_data <= 32'hdeadbeef;
          endcase
        end
        stub_cnt <= stub_mute ? 0 : stub_delay - 1;
      end else if (stub_cnt != 0) begin
        stub_cnt <= stub_cnt - 1;
        if (stub_cnt == 1) begin
          mem_op_r  <= 1'b1;
          mem_rdata <= stub_data;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request and follow it to its response (bounded), recording the controller side.
  task automatic do_req(
    input  logic        st,
    input  logic [2:0]  f3,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output logic [31:0] rdata,
    output logic        err,
    output int          lat,
    output int          en_cnt,
    output logic [1:0]  en_mode,
    output logic        en_we,
    output logic [23:0] en_addr,
    output logic [31:0] en_wdata,
    output logic        hold_ok,
    output logic        post_valid,
    output logic        post_ready
  );
    int guard;
    en_cnt = 0; en_mode = 2'b11; en_we = 1'bx; en_addr = 24'h0; en_wdata = 32'h0;
    hold_ok = 1'b1; rdata = 32'h0; err = 1'b0;
    guard = 0;
    while (!req_ready && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b0; req_addr = 32'h0; req_wdata = 32'h0;
    lat = 1;
    while (!resp_valid && lat < 40) begin
      if (mem_enable) begin
        en_cnt++;
        en_mode = mem_mode; en_we = mem_we; en_addr = mem_addr; en_wdata = mem_wdata;
      end else if (en_cnt > 0) begin
        if (mem_addr !== en_addr || mem_mode !== en_mode || mem_we !== en_we || mem_wdata !== en_wdata)
          hold_ok = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    if (!resp_valid) lat = -1;
    if (mem_enable) en_cnt++;
    rdata = resp_rdata;
    err   = resp_err;
    @(posedge clk); #1;
    post_valid = resp_valid;
    post_ready = req_ready;
  endtask

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    logic [1:0]  exp_mode;
  } vec_t;

  vec_t vecs[22];

  initial begin
    logic [31:0] rd;
    logic        er, ev, pv, pr, we_s, hold;
    logic [1:0]  md;
    logic [23:0] ad;
    logic [31:0] wds;
    int          lt, ec, rv_cnt;

    vecs[0]  = '{1'b1, F3_LW,  32'h00000010, 32'hddccbbaa, 32'h00000000, 1'b0, 6, MODE_WORD};
    vecs[1]  = '{1'b0, F3_LW,  32'h00000010, 32'h00000000, 32'hddccbbaa, 1'b0, 6, MODE_WORD};
    vecs[2]  = '{1'b1, F3_LB,  32'h00000003, 32'h12345680, 32'h00000000, 1'b0, 6, MODE_BYTE};
    vecs[3]  = '{1'b0, F3_LB,  32'h00000003, 32'h00000000, 32'hffffff80, 1'b0, 6, MODE_BYTE};
    vecs[4]  = '{1'b0, F3_LBU, 32'h00000003, 32'h00000000, 32'h00000080, 1'b0, 6, MODE_BYTE};
    vecs[5]  = '{1'b1, F3_LH,  32'h00000006, 32'h12345678, 32'h00000000, 1'b0, 6, MODE_HALF};
    vecs[6]  = '{1'b0, F3_LH,  32'h00000006, 32'h00000000, 32'h00005678, 1'b0, 6, MODE_HALF};
    vecs[7]  = '{1'b1, F3_LH,  32'h00000008, 32'habcdc001, 32'h00000000, 1'b0, 6, MODE_HALF};
    vecs[8]  = '{1'b0, F3_LH,  32'h00000008, 32'h00000000, 32'hffffc001, 1'b0, 6, MODE_HALF};
    vecs[9]  = '{1'b0, F3_LHU, 32'h00000008, 32'h00000000, 32'h0000c001, 1'b0, 6, MODE_HALF};
    vecs[10] = '{1'b0, F3_LW,  32'h00000000, 32'h00000000, 32'h80000000, 1'b0, 6, MODE_WORD};
    vecs[11] = '{1'b0, F3_LW,  32'h00000004, 32'h00000000, 32'h56780000, 1'b0, 6, MODE_WORD};
    vecs[12] = '{1'b0, F3_LW,  32'h00000002, 32'h00000000, 32'h00000000, 1'b1, 1, MODE_WORD};
    vecs[13] = '{1'b0, F3_LHU, 32'h00000008, 32'h00000000, 32'h0000c001, 1'b0, 6, MODE_HALF};
    vecs[14] = '{1'b0, F3_LH,  32'h00000001, 32'h00000000, 32'h00000000, 1'b1, 1, MODE_HALF};
    vecs[15] = '{1'b0, F3_LW,  32'h01000000, 32'h00000000, 32'h00000000, 1'b1, 1, MODE_WORD};
    vecs[16] = '{1'b1, F3_LB,  32'h01000000, 32'h000000ff, 32'h00000000, 1'b1, 1, MODE_BYTE};
    vecs[17] = '{1'b0, 3'b011, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1, MODE_WORD};
    vecs[18] = '{1'b1, F3_LBU, 32'h00000000, 32'h00000011, 32'h00000000, 1'b1, 1, MODE_BYTE};
    vecs[19] = '{1'b1, F3_LW,  32'h00000005, 32'h00000022, 32'h00000000, 1'b1, 1, MODE_WORD};
    vecs[20] = '{1'b0, 3'b110, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1, MODE_WORD};
    vecs[21] = '{1'b0, F3_LB,  32'h00ffffff, 32'h00000000, 32'h00000000, 1'b0, 6, MODE_BYTE};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'h1);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_err", 32'(resp_err), 32'h0);
    chk("rst_mem_enable", 32'(mem_enable), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_mode", 32'(mem_mode), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed request table
    for (int i = 0; i < $size(vecs); i++) begin
      do_req(vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].wd,
             rd, er, lt, ec, md, we_s, ad, wds, hold, pv, pr);
      chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("v%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      chk($sformatf("v%0d_latency", i), 32'(lt), 32'(vecs[i].exp_lat));
      chk($sformatf("v%0d_enables", i), 32'(ec), vecs[i].exp_err ? 32'h0 : 32'h1);
      chk($sformatf("v%0d_pulse_end", i), 32'(pv), 32'h0);
      chk($sformatf("v%0d_ready_back", i), 32'(pr), 32'h1);
      if (!vecs[i].exp_err) begin
        chk($sformatf("v%0d_mode", i), 32'(md), 32'(vecs[i].exp_mode));
        chk($sformatf("v%0d_we", i), 32'(we_s), 32'(vecs[i].st));
        chk($sformatf("v%0d_addr", i), 32'(ad), {8'h0, vecs[i].addr[23:0]});
        chk($sformatf("v%0d_wdata", i), wds, vecs[i].wd);
        chk($sformatf("v%0d_hold", i), 32'(hold), 32'h1);
      end
    end
    chk("mem_byte02", 32'(mem[2]), 32'h00);
    chk("mem_byte03", 32'(mem[3]), 32'h80);
    chk("mem_byte05", 32'(mem[5]), 32'h00);
    chk("mem_byte06", 32'(mem[6]), 32'h78);
    chk("mem_byte07", 32'(mem[7]), 32'h56);

    // Controller never answers: timeout after 15 WAIT cycles
    do_req(1'b0, F3_LW, 32'h10, 32'h0, rd, er, lt, ec, md, we_s, ad, wds, hold, pv, pr);
    chk("pre_to_rdata", rd, 32'hddccbbaa);
    stub_mute = 1'b1;
    do_req(1'b0, F3_LW, 32'h10, 32'h0, rd, er, lt, ec, md, we_s, ad, wds, hold, pv, pr);
    stub_mute = 1'b0;
    chk("to_err", 32'(er), 32'h1);
    chk("to_rdata", rd, 32'h0);
    chk("to_latency", 32'(lt), 32'd17);
    chk("to_enables", 32'(ec), 32'h1);
    chk("to_ready_back", 32'(pr), 32'h1);

    // op_r one cycle too late lands in RESP and must be ignored
    stub_delay = 16;
    do_req(1'b0, F3_LW, 32'h10, 32'h0, rd, er, lt, ec, md, we_s, ad, wds, hold, pv, pr);
    chk("late_err", 32'(er), 32'h1);
    chk("late_latency", 32'(lt), 32'd17);
    rv_cnt = 0;
    ev = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (resp_valid) rv_cnt++;
      if (resp_rdata !== 32'h0 || resp_err !== 1'b1) ev = 1'b0;
      @(posedge clk); #1;
    end
    chk("late_no_extra_resp", 32'(rv_cnt), 32'h0);
    chk("late_resp_stable", 32'(ev), 32'h1);

    // op_r on the final WAIT cycle wins over the timeout
    stub_delay = 15;
    do_req(1'b0, F3_LW, 32'h10, 32'h0, rd, er, lt, ec, md, we_s, ad, wds, hold, pv, pr);
    chk("edge_err", 32'(er), 32'h0);
    chk("edge_rdata", rd, 32'hddccbbaa);
    chk("edge_latency", 32'(lt), 32'd17);
    stub_delay = 4;

    // Reset asserted while the access is in WAIT
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = F3_LW; req_addr = 32'h10; req_wdata = 32'h0;
    @(posedge clk); #1;
    req_valid = 1'b0; req_funct3 = 3'b0; req_addr = 32'h0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(req_ready), 32'h1);
    chk("mid_rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("mid_rst_rdata", resp_rdata, 32'h0);
    chk("mid_rst_err", 32'(resp_err), 32'h0);
    chk("mid_rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("mid_rst_mem_enable", 32'(mem_enable), 32'h0);
    chk("mid_rst_mem_mode", 32'(mem_mode), 32'h0);
    rv_cnt = 0;
    repeat (3) begin @(posedge clk); #1; if (resp_valid) rv_cnt++; end
    rst_n = 1'b1;
    repeat (8) begin @(posedge clk); #1; if (resp_valid) rv_cnt++; end
    chk("mid_rst_no_resp", 32'(rv_cnt), 32'h0);
    do_req(1'b0, F3_LW, 32'h10, 32'h0, rd, er, lt, ec, md, we_s, ad, wds, hold, pv, pr);
    chk("post_rst_rdata", rd, 32'hddccbbaa);
    chk("post_rst_err", 32'(er), 32'h0);
    chk("post_rst_latency", 32'(lt), 32'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
